stream_reduce: RTL
==================

Name: stream_reduce

Overview:
Parametrised successor to the generated single-purpose stream sum reducer. It consumes one list stream element per cycle and folds it into an accumulator. The fold operation is selected per transaction, and the initial value is loaded per transaction. It reports the result, element count and an overflow flag through explicit valid/ready handshakes. It sits between a list producer (ap01-style element source) and the consumer of the reduced scalar in generated pipelines.

Parameters:
WIDTH, 32, data and accumulator width in bits (>=2)
CNT_W, 16, element counter width
SENTINEL_EN, 1, 1: an all-ones in_data beat terminates the stream (nil marker, not folded); 0: the in_last beat terminates the stream (that beat is folded)
SAT, 0, 1: SUM saturates to the signed limits; 0: SUM wraps

Ports:
clk  in  1  clock
nrst  in  1  reset, synchronous, active-low
start_valid  in  1  transaction request
start_ready  out  1  high only in IDLE
start_op  in  3  0 SUM, 1 MIN (signed), 2 MAX (signed), 3 AND, 4 OR, 5 XOR, 6 COUNT, 7 reserved (acts as SUM)
start_init  in  WIDTH  initial accumulator value
in_valid  in  1  element valid
in_ready  out  1  high only in RUN
in_data  in  WIDTH  element
in_last  in  1  end marker (used only when SENTINEL_EN=0)
out_valid  out  1  result valid, high only in DONE
out_ready  in  1  result accepted
out_data  out  WIDTH  reduced value
out_count  out  CNT_W  number of folded elements
out_ovf  out  1  sticky overflow for this transaction

Behaviour:
- One clock; reset is synchronous and active-low (nrst sampled on the clk rising edge). Reset forces IDLE, accumulator, count and ovf to 0, and all outputs to 0 except start_ready=1. Reset mid-transaction abandons the transaction with no result emitted.
- FSM IDLE -> RUN on start_valid&&start_ready: latch op and init; acc<=start_init, count<=0, ovf<=0.
- RUN: in_ready=1. Each in_valid&&in_ready beat is processed in that cycle; the new acc is visible the next cycle. Throughput is 1 element per cycle, and in_valid gaps are allowed.
- Terminating beat: SENTINEL_EN=1 with in_data all ones. This beat is not folded, the count is unchanged, and in_last is ignored. SENTINEL_EN=0 with in_last=1: the beat is folded, then the stream ends.
- RUN -> DONE in the cycle after the terminating beat. out_valid=1, and out_data/out_count/out_ovf hold stable until out_ready.
- DONE -> IDLE on out_valid&&out_ready. start_ready rises the next cycle, so there is no start overlap with DONE.
- Folds:
  - SUM: acc+d. On signed overflow, ovf<=1. SAT=1 clamps to 0x7F..F / 0x80..0; SAT=0 wraps.
  - MIN/MAX: signed compare; on a tie acc is unchanged.
  - AND/OR/XOR: bitwise.
  - COUNT: acc+1 with wrap; ovf<=1 on wrap.
- count increments per folded beat and saturates at all ones. Saturation also sets ovf.
- Empty stream (terminating beat first) gives out_data=init, out_count=0, out_ovf=0.
- Latency: result valid exactly 1 cycle after the terminating beat is accepted.
- Beats offered in IDLE/DONE are not consumed (in_ready=0).

Test Plan:
- WIDTH=32, SENTINEL_EN=1, op SUM, init 0; stream 1,2,3,4,0xFFFFFFFF -> out_data=10, out_count=4, out_ovf=0, out_valid 1 cycle after the sentinel.
- Empty stream: op SUM, init 7; first beat 0xFFFFFFFF -> out_data=7, out_count=0.
- SAT=1, op SUM, init 0x7FFFFFF0; beats 0x20, 0x1, sentinel -> out_data=0x7FFFFFFF, out_ovf=1. Same stimulus with SAT=0 -> out_data=0x80000011, out_ovf=1.
- SENTINEL_EN=0, op MAX, init 0x80000000; beats -5, 3, 9 (last=1) with 2-cycle in_valid gaps -> out_data=9, out_count=3.
- Op XOR, init 0xFF; beats 0x0F, 0xF0, sentinel; out_ready held low 5 cycles -> out_data=0x00 stable for all 5 cycles. No new start is accepted until 1 cycle after the handshake.
- Assert nrst low during RUN after 2 beats -> next cycle: IDLE, start_ready=1, out_valid=0. A new transaction then gives a result independent of the aborted beats.

Source files
------------

// File: rtl/stream_reduce_if.sv
// Handshake bundle for stream_reduce: start request, element stream and result channel.
// The master side is the pipeline around the reducer; the slave side is the reducer.
interface stream_reduce_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             start_valid;
    logic             start_ready;
    logic [2:0]       start_op;
    logic [WIDTH-1:0] start_init;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output start_valid, start_op, start_init,
        output in_valid, in_data, in_last,
        output out_ready,
        input  start_ready, in_ready,
        input  out_valid, out_data, out_count, out_ovf
    );

    modport slave (
        input  start_valid, start_op, start_init,
        input  in_valid, in_data, in_last,
        input  out_ready,
        output start_ready, in_ready,
        output out_valid, out_data, out_count, out_ovf
    );
endinterface

// File: rtl/stream_reduce.sv
// Stream reducer: folds one list element per cycle into an accumulator using a per-transaction
// operation and initial value, then returns result, element count and sticky overflow.
module stream_reduce #(
    parameter int WIDTH       = 32,
    parameter int CNT_W       = 16,
    parameter bit SENTINEL_EN = 1'b1,
    parameter bit SAT         = 1'b0
) (
    input  logic           clk,
    input  logic           nrst,
    stream_reduce_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for a transaction request, start_ready=1
    // RUN   | consuming elements, in_ready=1
    // DONE  | holding the result, out_valid=1 until out_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MIN = 3'd1;
    localparam logic [2:0] OP_MAX = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_CNT = 3'd6;

    localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [2:0]       op, op_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             ovf, ovf_nxt;

    logic [WIDTH-1:0] sum, fold_val;
    logic             fold_ovf;
    logic             is_nil, is_term;

    // The nil marker only exists in sentinel mode; otherwise all-ones is ordinary data.
    assign is_nil  = SENTINEL_EN && (&bus.in_data);
    assign is_term = SENTINEL_EN ? is_nil : bus.in_last;

    always_comb begin
        sum      = acc + bus.in_data;
        fold_val = sum;
        fold_ovf = 1'b0;
        case (op)
            OP_MIN: fold_val = ($signed(bus.in_data) < $signed(acc)) ? bus.in_data : acc;
            OP_MAX: fold_val = ($signed(bus.in_data) > $signed(acc)) ? bus.in_data : acc;
            OP_AND: fold_val = acc & bus.in_data;
            OP_OR:  fold_val = acc | bus.in_data;
            OP_XOR: fold_val = acc ^ bus.in_data;
            OP_CNT: begin
                fold_val = acc + ONE_W;
                fold_ovf = &acc;
            end
            default: begin
                // SUM and the reserved code: signed overflow when operands agree in sign
                // but the result does not.
                fold_ovf = (acc[WIDTH-1] == bus.in_data[WIDTH-1]) &&
                           (sum[WIDTH-1] != acc[WIDTH-1]);
                if (SAT && fold_ovf) begin
                    fold_val = acc[WIDTH-1] ? S_MIN : S_MAX;
                end
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        op_nxt    = op;
        acc_nxt   = acc;
        count_nxt = count;
        ovf_nxt   = ovf;
        case (state)
            IDLE: begin
                if (bus.start_valid) begin
                    state_nxt = RUN;
                    op_nxt    = bus.start_op;
                    acc_nxt   = bus.start_init;
                    count_nxt = '0;
                    ovf_nxt   = 1'b0;
                end
            end
            RUN: begin
                if (bus.in_valid) begin
                    if (!is_nil) begin
                        acc_nxt = fold_val;
                        if (fold_ovf) begin
                            ovf_nxt = 1'b1;
                        end
                        if (&count) begin
                            ovf_nxt = 1'b1;
                        end else begin
                            count_nxt = count + ONE_C;
                        end
                    end
                    if (is_term) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= IDLE;
            op    <= 3'd0;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            op    <= op_nxt;
            acc   <= acc_nxt;
            count <= count_nxt;
            ovf   <= ovf_nxt;
        end
    end

    assign bus.start_ready = (state == IDLE);
    assign bus.in_ready    = (state == RUN);
    assign bus.out_valid   = (state == DONE);
    assign bus.out_data    = acc;
    assign bus.out_count   = count;
    assign bus.out_ovf     = ovf;
endmodule
